// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: 8-bit FIFO controller over an external 512x8 dual-port RAM with a registered read port and one output head register.
// Latency: a word pushed in cycle N is presented on dout_valid/dout in cycle N+2 at the earliest; sustains 1 push + 1 pop per cycle.
// Backpressure: full rejects pushes and pulses overflow; dout_ready low holds the head word. Optional RAM_FIFO_LEVEL_EN adds almost_full/almost_empty.
module ram_fifo_ctrl #(
    parameter int unsigned AFULL_LVL  = 448,
    parameter int unsigned AEMPTY_LVL = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    output logic       full,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic [9:0] count,
    output logic       overflow,
    output logic       ram_wea,
    output logic [8:0] ram_addra,
    output logic [7:0] ram_dina,
    output logic       ram_reb,
    output logic [8:0] ram_addrb,
    input  logic [7:0] ram_doutb,
    output logic       ram_rea,
    output logic       ram_web
`ifdef RAM_FIFO_LEVEL_EN
    ,
    output logic       almost_full,
    output logic       almost_empty
`endif
);

    logic [8:0] wr_ptr;
    logic [8:0] rd_ptr;
    logic [9:0] ram_level;
    logic       push_acc;
    logic       rd_issue;
    logic       pop;

    // ram_level only counts words written in earlier cycles, so a read never targets the slot being written now.
    always_comb begin
        full     = (ram_level == 10'd512);
        pop      = dout_valid && dout_ready;
        push_acc = push && !full && !rst;
        rd_issue = (ram_level != 10'd0) && (!dout_valid || pop) && !rst;
    end

    assign ram_wea   = push_acc;
    assign ram_addra = wr_ptr;
    assign ram_dina  = din;
    assign ram_reb   = rd_issue;
    assign ram_addrb = rd_ptr;
    assign ram_rea   = 1'b0;
    assign ram_web   = 1'b0;
    assign dout      = ram_doutb;
    assign count     = ram_level + {9'd0, dout_valid};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= 9'd0;
            rd_ptr     <= 9'd0;
            ram_level  <= 10'd0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 9'd1;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + 9'd1;
            end
            case ({push_acc, rd_issue})
                2'b10:   ram_level <= ram_level + 10'd1;
                2'b01:   ram_level <= ram_level - 10'd1;
                default: ram_level <= ram_level;
            endcase
            if (rd_issue) begin
                dout_valid <= 1'b1;
            end else if (pop) begin
                dout_valid <= 1'b0;
            end
            overflow <= push && full;
        end
    end

`ifdef RAM_FIFO_LEVEL_EN
    localparam logic [9:0] AFULL_L  = AFULL_LVL[9:0];
    localparam logic [9:0] AEMPTY_L = AEMPTY_LVL[9:0];

    assign almost_full  = (count >= AFULL_L);
    assign almost_empty = (count <= AEMPTY_L);
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomized scoreboard bench for ram_fifo_ctrl with a behavioural 512x8 RAM and an arrival-time reference model.
module tb_ram_fifo_ctrl;

    localparam int AF = 448;
    localparam int AE = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic [7:0] din = 8'd0;
    logic       dout_ready = 1'b0;
    logic       full, dout_valid, overflow;
    logic [7:0] dout;
    logic [9:0] count;
    logic       ram_wea, ram_reb, ram_rea, ram_web;
    logic [8:0] ram_addra, ram_addrb;
    logic [7:0] ram_dina;
    logic [7:0] ram_doutb = 8'd0;
`ifdef RAM_FIFO_LEVEL_EN
    logic       almost_full, almost_empty;
`endif

    ram_fifo_ctrl #(.AFULL_LVL(AF), .AEMPTY_LVL(AE)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .din        (din),
        .full       (full),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .count      (count),
        .overflow   (overflow),
        .ram_wea    (ram_wea),
        .ram_addra  (ram_addra),
        .ram_dina   (ram_dina),
        .ram_reb    (ram_reb),
        .ram_addrb  (ram_addrb),
        .ram_doutb  (ram_doutb),
        .ram_rea    (ram_rea),
        .ram_web    (ram_web)
`ifdef RAM_FIFO_LEVEL_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, registered read that holds while reb is low.
    logic [7:0] mem [512];
    always @(posedge clk) begin
        if (ram_wea) mem[ram_addra] <= ram_dina;
        if (ram_reb) ram_doutb <= mem[ram_addrb];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    int n_acc = 0;
    int n_rx = 0;
    int n_disc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: each word is presented no earlier than 2 cycles after its push
    // and no earlier than the cycle after its predecessor was popped.
    typedef struct {
        logic [7:0] d;
        int         p;
    } ent_t;
    ent_t       mq[$];
    logic [7:0] exp_q[$];
    int         last_pop = -1000;
    bit         ovf_next = 1'b0;
    bit         chk_en = 1'b0;
    logic       exp_valid, exp_full, exp_ovf, exp_wea;
    logic [9:0] exp_count;

    task automatic step(input bit p, input logic [7:0] d, input bit r, input bit rs, output bit acc);
        bit hv;
        int vt;
        @(posedge clk);
        #1;
        hv = 1'b0;
        if (mq.size() > 0) begin
            vt = mq[0].p + 2;
            if (last_pop + 1 > vt) vt = last_pop + 1;
            hv = (cyc >= vt);
        end
        exp_valid = hv;
        exp_count = 10'(mq.size());
        exp_full  = ((mq.size() - int'(hv)) == 512);
        exp_ovf   = ovf_next;
        acc       = p && !exp_full && !rs;
        exp_wea   = acc;
        push = p; din = d; dout_ready = r; rst = rs;
        if (rs) begin
            mq.delete();
            last_pop = -1000;
            ovf_next = 1'b0;
        end else begin
            if (hv && r) begin
                void'(mq.pop_front());
                last_pop = cyc;
            end
            if (acc) begin
                mq.push_back('{d, cyc});
                exp_q.push_back(d);
                n_acc++;
            end
            ovf_next = p && exp_full;
        end
        chk_en = 1'b1;
    endtask

    // Monitor: compares status every cycle and pops the scoreboard whenever the DUT hands over a word.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 32'(count), 32'(exp_count));
            chk("full", 32'(full), 32'(exp_full));
            chk("dout_valid", 32'(dout_valid), 32'(exp_valid));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            chk("ram_wea", 32'(ram_wea), 32'(exp_wea));
            chk("ram_rea_web", 32'({ram_rea, ram_web}), 32'(0));
`ifdef RAM_FIFO_LEVEL_EN
            chk("almost_full", 32'(almost_full), 32'(int'(exp_count) >= AF));
            chk("almost_empty", 32'(almost_empty), 32'(int'(exp_count) <= AE));
`endif
            if (rst) begin
                chk("rst_no_wea_reb", 32'({ram_wea, ram_reb}), 32'(0));
                n_disc += exp_q.size();
                exp_q.delete();
            end else if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(1), 32'(0));
                end else begin
                    chk("dout_data", 32'(dout), 32'(exp_q[0]));
                    if (dout_ready) begin
                        void'(exp_q.pop_front());
                        n_rx++;
                    end
                end
            end
        end
    end

    initial begin
        bit a;
        int sent;
        repeat (2) @(posedge clk);

        // Reset state and idle.
        repeat (3) step(1'b0, 8'd0, 1'b1, 1'b0, a);

        // Single word held until consumed.
        step(1'b1, 8'hA5, 1'b0, 1'b0, a);
        repeat (6) step(1'b0, 8'd0, 1'b0, 1'b0, a);
        step(1'b0, 8'd0, 1'b1, 1'b0, a);
        repeat (3) step(1'b0, 8'd0, 1'b1, 1'b0, a);

        // Continuous stream 0x00..0xFF with the consumer always ready.
        for (int i = 0; i < 256; i++) step(1'b1, 8'(i), 1'b1, 1'b0, a);
        repeat (4) step(1'b0, 8'd0, 1'b1, 1'b0, a);
        chk("stream256_drained", 32'(exp_q.size()), 32'(0));

        // Fill to full, then one more push to be rejected.
        for (int i = 0; i < 514; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, a);
        repeat (3) step(1'b0, 8'd0, 1'b0, 1'b0, a);
        chk("fill_count", 32'(count), 32'(513));

        // Push and pop together while full, then a push that must now be accepted.
        step(1'b1, 8'h3C, 1'b1, 1'b0, a);
        step(1'b1, 8'hC3, 1'b0, 1'b0, a);
        chk("push_after_full_accepted", 32'(exp_q[exp_q.size()-1]), 32'(8'hC3));
        repeat (600) step(1'b0, 8'd0, 1'b1, 1'b0, a);
        chk("full_drained", 32'(exp_q.size()), 32'(0));

        // 700 random words with a random consumer; pointers wrap.
        sent = 0;
        for (int i = 0; i < 5000 && sent < 700; i++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, a);
            if (a) sent++;
        end
        chk("stream700_sent", 32'(sent), 32'(700));
        repeat (700) step(1'b0, 8'd0, 1'b1, 1'b0, a);
        chk("stream700_drained", 32'(exp_q.size()), 32'(0));

        // Reset with 37 words held and a read in flight.
        for (int i = 0; i < 38; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, a);
        repeat (2) step(1'b0, 8'd0, 1'b0, 1'b0, a);
        step(1'b0, 8'd0, 1'b1, 1'b0, a);
        step(1'b1, 8'h77, 1'b1, 1'b1, a);
        step(1'b0, 8'd0, 1'b1, 1'b0, a);
        repeat (2) step(1'b0, 8'd0, 1'b1, 1'b0, a);

        // Clean operation after the mid-stream reset.
        for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, a);
        repeat (50) step(1'b0, 8'd0, 1'b1, 1'b0, a);

        @(negedge clk);
        #1;
        chk("final_drained", 32'(exp_q.size()), 32'(0));
        chk("words_accounted", 32'(n_rx + n_disc), 32'(n_acc));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
